// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, instruction register and imem request/ready handshake
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_en                level request to fetch the word at pc
//   pc_update, pc_src,      one-cycle PC commit; pc_src selects pc+4 (0) or
//   pc_target               pc_target (1)
//   imem_req, imem_addr     request and address towards instruction memory
//   imem_ready, imem_rdata  memory response, captured on the first ready edge
//   instr, opcode           instruction register and its opcode field
//   pc, pc_plus4            current PC and its sequential successor
//   instr_valid             instr holds the word fetched from pc
//   fetch_busy              request outstanding
//   misalign_err            sticky: unaligned branch/jump target rejected
//   protocol_err            sticky: pc_update seen while a fetch was outstanding
module instruction_fetch #(
    parameter int                    WORDSIZE         = 64,
    parameter int                    INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0]   RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    input  logic                        pc_update,
    input  logic                        pc_src,
    input  logic [WORDSIZE-1:0]         pc_target,
    output logic                        imem_req,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic                        imem_ready,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    output logic [INSTRUCTION_SIZE-1:0] instr,
    output logic [6:0]                  opcode,
    output logic [WORDSIZE-1:0]         pc,
    output logic [WORDSIZE-1:0]         pc_plus4,
    output logic                        instr_valid,
    output logic                        fetch_busy,
    output logic                        misalign_err,
    output logic                        protocol_err
);

    localparam logic [INSTRUCTION_SIZE-1:0] NOP     = INSTRUCTION_SIZE'(32'h0000_0013);
    localparam logic [WORDSIZE-1:0]         PC_STEP = WORDSIZE'(4);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [WORDSIZE-1:0]           pc_q, pc_d;
    logic [INSTRUCTION_SIZE-1:0]   instr_q, instr_d;
    logic                          valid_q, valid_d;
    logic                          misalign_q, misalign_d;
    logic                          protocol_q, protocol_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            protocol_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            protocol_q <= protocol_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        protocol_d = protocol_q;
        case (state_q)
            S_IDLE: begin
                // A PC commit wins over a fetch request in the same cycle;
                // instr no longer describes pc, even if the target is rejected.
                if (pc_update) begin
                    valid_d = 1'b0;
                    if (!pc_src) begin
                        pc_d = pc_q + PC_STEP;
                    end else if (pc_target[1:0] == 2'b00) begin
                        pc_d = pc_target;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end else if (fetch_en) begin
                    state_d = S_WAIT;
                    valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                // pc must stay stable while the request is outstanding.
                if (pc_update) begin
                    protocol_d = 1'b1;
                end
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_req     = (state_q == S_WAIT);
    assign fetch_busy   = (state_q == S_WAIT);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign opcode       = instr_q[6:0];
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + PC_STEP;
    assign instr_valid  = valid_q;
    assign misalign_err = misalign_q;
    assign protocol_err = protocol_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch against a transaction-level model
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, pc_update, pc_src, imem_ready;
    logic [63:0] pc_target;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_busy, misalign_err, protocol_err;
    logic [63:0] imem_addr, pc, pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the fetch stage should be holding.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid, m_busy, m_mis, m_prot;

    always #5 clk = ~clk;

    instruction_fetch #(.WORDSIZE(64), .INSTRUCTION_SIZE(32), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_update(pc_update),
        .pc_src(pc_src), .pc_target(pc_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .fetch_busy(fetch_busy),
        .misalign_err(misalign_err), .protocol_err(protocol_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'd0; m_instr = 32'h0000_0013;
        m_valid = 1'b0; m_busy = 1'b0; m_mis = 1'b0; m_prot = 1'b0;
    endtask

    task automatic compare_all();
        check("imem_req", imem_req, m_busy);
        check("fetch_busy", fetch_busy, m_busy);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 64'd4);
        check("instr", instr, m_instr);
        check("opcode", opcode, m_instr[6:0]);
        check("instr_valid", instr_valid, m_valid);
        check("misalign_err", misalign_err, m_mis);
        check("protocol_err", protocol_err, m_prot);
        if (m_busy) check("imem_addr", imem_addr, m_pc);
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic fe, input logic pu, input logic src,
                        input logic [63:0] tgt, input logic rdy, input logic [31:0] rdata);
        fetch_en = fe; pc_update = pu; pc_src = src; pc_target = tgt;
        imem_ready = rdy; imem_rdata = rdata;
        if (!m_busy) begin
            if (pu) begin
                m_valid = 1'b0;
                if (!src)                 m_pc = m_pc + 64'd4;
                else if (tgt % 4 == 0)    m_pc = tgt;
                else                      m_mis = 1'b1;
            end else if (fe) begin
                m_busy = 1'b1; m_valid = 1'b0;
            end
        end else begin
            if (pu) m_prot = 1'b1;
            if (rdy) begin
                m_instr = rdata; m_valid = 1'b1; m_busy = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 0; pc_update = 0; pc_src = 0; imem_ready = 0;
        pc_target = '0; imem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_opcode", opcode, 64'h13);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch with three wait states.
        step(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'hdead_beef);
        step(0, 0, 0, 0, 1, 32'h0050_0093);
        check("fetch_instr", instr, 64'h0050_0093);
        check("fetch_opcode", opcode, 64'h13);
        check("fetch_valid", instr_valid, 64'd1);

        // Sequential update, then wrap at the top of the address space.
        step(0, 1, 1, 64'h100, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("seq_pc", pc, 64'h104);
        step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("wrap_pc", pc, 64'h0);

        // Branch target taken together with fetch_en: update wins, no request.
        step(1, 1, 1, 64'h2000, 0, 0);
        check("prec_req", imem_req, 64'd0);
        check("branch_pc", pc, 64'h2000);
        step(1, 0, 0, 0, 0, 0);
        check("branch_addr", imem_addr, 64'h2000);
        // pc_update during WAIT is flagged and ignored.
        step(0, 1, 1, 64'h4000, 0, 0);
        check("prot_err", protocol_err, 64'd1);
        step(0, 0, 0, 0, 1, 32'h0000_006f);
        check("prot_pc", pc, 64'h2000);
        check("prot_valid", instr_valid, 64'd1);

        // Misaligned target rejected.
        step(0, 1, 1, 64'h2002, 0, 0);
        check("mis_pc", pc, 64'h2000);
        check("mis_err", misalign_err, 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 1), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
                 t, ($urandom_range(0, 2) == 0), $urandom);
        end
        check("mis_sticky", misalign_err, 64'd1);

        // Drain any outstanding fetch, start a new one, reset in mid-WAIT.
        for (int i = 0; i < 4 && m_busy; i++) step(0, 0, 0, 0, 1, $urandom);
        check("drained", fetch_busy, 64'd0);
        step(1, 0, 0, 0, 0, 0);
        check("wait_req", imem_req, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_req", imem_req, 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_opcode", opcode, 64'h13);
        check("rst_valid", instr_valid, 64'd0);
        check("rst_mis", misalign_err, 64'd0);
        check("rst_prot", protocol_err, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h1234_5013);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
